// File: rtl/de_regfile_scoreboard.sv
// Decode-stage register file with per-register pending-write counters.
// Stalls on RAW/saturation hazards, bypasses same-cycle writeback, and accepts squash releases.
module de_regfile_scoreboard #(
  parameter int DBITS = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int PBITS = 2,
  localparam int RBITS = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*RBITS-1:0]   i_rd_addr,
  input  logic [NREAD-1:0]         i_rd_en,
  output logic [NREAD*DBITS-1:0]   o_rd_data,
  input  logic                     i_issue_valid,
  input  logic                     i_issue_wr,
  input  logic [RBITS-1:0]         i_issue_rd,
  output logic                     o_issue_stall,
  input  logic                     i_wb_valid,
  input  logic [RBITS-1:0]         i_wb_rd,
  input  logic [DBITS-1:0]         i_wb_data,
  input  logic                     i_kill_valid,
  input  logic [RBITS-1:0]         i_kill_rd,
  output logic                     o_pend_any,
  output logic                     o_err_underflow
);

  // Two extra bits hold the sum of wb and kill hits without overflow.
  localparam int CW = PBITS + 2;
  typedef logic [CW-1:0] wide_t;
  localparam logic [PBITS-1:0] CNT_MAX = '1;

  logic [DBITS-1:0] r_regs [NREGS];
  logic [PBITS-1:0] r_cnt  [NREGS];
  logic             r_pend_any;
  logic             r_err_underflow;

  logic [PBITS-1:0] w_cnt_next [NREGS];
  logic             w_pend_next;
  logic             w_underflow;
  logic             w_hazard;
  logic             w_sat;
  logic             w_accept;

  function automatic wide_t release_hits(input logic [RBITS-1:0] reg_idx);
    return wide_t'(i_wb_valid && (i_wb_rd == reg_idx)) +
           wide_t'(i_kill_valid && (i_kill_rd == reg_idx));
  endfunction

  // Read ports: register 0 reads as zero, then writeback bypass, then the array.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    o_rd_data = '0;
    w_hazard  = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      logic [RBITS-1:0] src;
      src = i_rd_addr[i*RBITS +: RBITS];
      if (src != '0) begin
        if (i_wb_valid && (i_wb_rd == src)) begin
          o_rd_data[i*DBITS +: DBITS] = i_wb_data;
        end else begin
          o_rd_data[i*DBITS +: DBITS] = r_regs[src];
        end
        if (i_rd_en[i] && (wide_t'(r_cnt[src]) > release_hits(src))) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  // A full counter only blocks a new writer if no reservation is released this cycle.
  always_comb begin
    w_sat = i_issue_wr && (i_issue_rd != '0) &&
            (r_cnt[i_issue_rd] == CNT_MAX) &&
            (release_hits(i_issue_rd) == '0);
  end

  assign o_issue_stall = i_issue_valid && (w_hazard || w_sat);
  assign w_accept      = i_issue_valid && !o_issue_stall;

  always_comb begin
    w_underflow = 1'b0;
    w_pend_next = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      wide_t cur;
      wide_t dec;
      logic  inc;
      cur = wide_t'(r_cnt[r]);
      dec = '0;
      inc = 1'b0;
      if (r != 0) begin
        inc = w_accept && i_issue_wr && (i_issue_rd == RBITS'(r));
        dec = release_hits(RBITS'(r));
        // Releases beyond the outstanding count are dropped and flagged.
        if (dec > cur) begin
          w_underflow = 1'b1;
          dec         = cur;
        end
      end
      w_cnt_next[r] = PBITS'(cur + wide_t'(inc) - dec);
      w_pend_next   = w_pend_next || (w_cnt_next[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset explicitly because reads of never-written registers must return 0 after reset.
      for (int r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_pend_any      <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      if (i_wb_valid && (i_wb_rd != '0)) begin
        r_regs[i_wb_rd] <= i_wb_data;
      end
      for (int r = 0; r < NREGS; r++) begin
        r_cnt[r] <= w_cnt_next[r];
      end
      r_pend_any      <= w_pend_next;
      r_err_underflow <= r_err_underflow || w_underflow;
    end
  end

  assign o_pend_any      = r_pend_any;
  assign o_err_underflow = r_err_underflow;

endmodule
